// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared types and defaults for the DMEM port arbiter
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      DBG  = 2'd2
   } rsp_owner_e;

   localparam int DEFAULT_STARVE_LIMIT = 8;
   localparam int STARVE_CNT_WIDTH     = 8;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - request/response and memory-side bus of the DMEM port arbiter
interface dmem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic                  cpu_req_valid;
   logic                  cpu_req_ready;
   logic [ADDR_WIDTH-1:0] cpu_req_addr;
   logic [DATA_WIDTH-1:0] cpu_req_wdata;
   logic [BE_WIDTH-1:0]   cpu_req_we;
   logic                  cpu_rsp_valid;
   logic [DATA_WIDTH-1:0] cpu_rsp_data;

   logic                  dbg_req_valid;
   logic                  dbg_req_ready;
   logic [ADDR_WIDTH-1:0] dbg_req_addr;
   logic [DATA_WIDTH-1:0] dbg_req_wdata;
   logic [BE_WIDTH-1:0]   dbg_req_we;
   logic                  dbg_rsp_valid;
   logic [DATA_WIDTH-1:0] dbg_rsp_data;

   logic                  mem_en;
   logic [BE_WIDTH-1:0]   mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] mem_dout;

   // slave: the arbiter itself; master: requesters plus the memory instance
   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_we,
      output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
      input  dbg_req_valid, dbg_req_addr, dbg_req_wdata, dbg_req_we,
      output dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      output mem_en, mem_we, mem_addr, mem_din,
      input  mem_dout
   );

   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_wdata, cpu_req_we,
      input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data,
      output dbg_req_valid, dbg_req_addr, dbg_req_wdata, dbg_req_we,
      input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_data,
      input  mem_en, mem_we, mem_addr, mem_din,
      output mem_dout
   );

endinterface

// File: rtl/dmem_port_arbiter_starve_counter.sv
// rtl/dmem_port_arbiter_starve_counter.sv - saturating aging counter with limit compare
module starve_counter
   import dmem_arb_pkg::*;
#(
   parameter int LIMIT = DEFAULT_STARVE_LIMIT,
   parameter int WIDTH = STARVE_CNT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);
   localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign at_limit = (count >= LIMIT_V);

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one synchronous-read DMEM between the CPU and the debug loader
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 14,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   dmem_port_arbiter_if.slave  bus
);
   localparam int BE_WIDTH = DATA_WIDTH / 8;

   logic       force_dbg;
   logic       at_limit;
   logic       cpu_grant;
   logic       dbg_grant;
   rsp_owner_e rsp_owner;

   // Grants are suppressed during reset so nothing reaches memory or the owner register.
   always_comb begin
      force_dbg = bus.dbg_req_valid && at_limit;
      dbg_grant = !rst && bus.dbg_req_valid && (force_dbg || !bus.cpu_req_valid);
      cpu_grant = !rst && bus.cpu_req_valid && !dbg_grant;
   end

   starve_counter #(
      .LIMIT (STARVE_LIMIT),
      .WIDTH (STARVE_CNT_WIDTH)
   ) u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (bus.dbg_req_valid && !dbg_grant),
      .clr      (!bus.dbg_req_valid || dbg_grant),
      .at_limit (at_limit)
   );

   assign bus.cpu_req_ready = cpu_grant;
   assign bus.dbg_req_ready = dbg_grant;

   always_comb begin
      bus.mem_en   = cpu_grant || dbg_grant;
      bus.mem_addr = dbg_grant ? bus.dbg_req_addr  : bus.cpu_req_addr;
      bus.mem_din  = dbg_grant ? bus.dbg_req_wdata : bus.cpu_req_wdata;
      bus.mem_we   = {BE_WIDTH{1'b0}};
      if (dbg_grant) begin
         bus.mem_we = bus.dbg_req_we;
      end else if (cpu_grant) begin
         bus.mem_we = bus.cpu_req_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_owner <= NONE;
      end else if (dbg_grant) begin
         rsp_owner <= DBG;
      end else if (cpu_grant) begin
         rsp_owner <= CPU;
      end else begin
         rsp_owner <= NONE;
      end
   end

   // mem_dout only becomes valid a cycle after the grant, so the data path stays combinational.
   always_comb begin
      bus.cpu_rsp_valid = !rst && (rsp_owner == CPU);
      bus.dbg_rsp_valid = !rst && (rsp_owner == DBG);
      bus.cpu_rsp_data  = bus.cpu_rsp_valid ? bus.mem_dout : {DATA_WIDTH{1'b0}};
      bus.dbg_rsp_data  = bus.dbg_rsp_valid ? bus.mem_dout : {DATA_WIDTH{1'b0}};
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for the DMEM port arbiter
module tb_dmem_port_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW    = 14;
   localparam int DW    = 32;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      rsp_owner_e    port;
      logic          chk_data;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   logic [DW-1:0] mem     [0:DEPTH-1];
   logic [DW-1:0] ref_mem [0:DEPTH-1];

   always #5 clk = ~clk;

   dmem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dmem_port_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STARVE_LIMIT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                           input logic [BW-1:0] we);
      logic [DW-1:0] w;
      w = old;
      for (int b = 0; b < BW; b++) begin
         if (we[b]) w[b*8 +: 8] = din[b*8 +: 8];
      end
      return w;
   endfunction

   // Write-first synchronous RAM, as the real DMEM behaves
   always @(posedge clk) begin
      if (bus.mem_en) begin
         mem[bus.mem_addr] <= merge(mem[bus.mem_addr], bus.mem_din, bus.mem_we);
         bus.mem_dout      <= merge(mem[bus.mem_addr], bus.mem_din, bus.mem_we);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic record(input rsp_owner_e port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [BW-1:0] we);
      exp_t e;
      check("mem_en", bus.mem_en, 1'b1);
      check("mem_addr", bus.mem_addr, a);
      check("mem_we", bus.mem_we, we);
      if (we != '0) check("mem_din", bus.mem_din, d);
      ref_mem[a] = merge(ref_mem[a], d, we);
      e.port     = port;
      e.chk_data = (we == '0);
      e.data     = ref_mem[a];
      sb.push_back(e);
   endtask

   task automatic monitor_step();
      exp_t e;
      if (rst) begin
         sb.delete();
         check("reset_ctrl", {bus.cpu_req_ready, bus.dbg_req_ready, bus.mem_en, bus.mem_we,
                              bus.cpu_rsp_valid, bus.dbg_rsp_valid}, '0);
         check("reset_data", {bus.cpu_rsp_data, bus.dbg_rsp_data}, '0);
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_valid", {bus.cpu_rsp_valid, bus.dbg_rsp_valid},
                  (e.port == CPU) ? 2'b10 : 2'b01);
            if (e.port == CPU) begin
               if (e.chk_data) check("cpu_rsp_data", bus.cpu_rsp_data, e.data);
               check("dbg_rsp_data_idle", bus.dbg_rsp_data, '0);
            end else begin
               if (e.chk_data) check("dbg_rsp_data", bus.dbg_rsp_data, e.data);
               check("cpu_rsp_data_idle", bus.cpu_rsp_data, '0);
            end
         end else begin
            check("no_rsp", {bus.cpu_rsp_valid, bus.dbg_rsp_valid}, 2'b00);
         end
         check("one_grant", bus.cpu_req_ready && bus.dbg_req_ready, 1'b0);
         if (bus.cpu_req_valid && bus.cpu_req_ready)
            record(CPU, bus.cpu_req_addr, bus.cpu_req_wdata, bus.cpu_req_we);
         else if (bus.dbg_req_valid && bus.dbg_req_ready)
            record(DBG, bus.dbg_req_addr, bus.dbg_req_wdata, bus.dbg_req_we);
         else
            check("idle_mem", {bus.mem_en, bus.mem_we}, '0);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_step();
      end
   end

   task automatic drive(input rsp_owner_e port, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] we);
      if (port == CPU) begin
         bus.cpu_req_valid = v;
         bus.cpu_req_addr  = a;
         bus.cpu_req_wdata = d;
         bus.cpu_req_we    = we;
      end else begin
         bus.dbg_req_valid = v;
         bus.dbg_req_addr  = a;
         bus.dbg_req_wdata = d;
         bus.dbg_req_we    = we;
      end
   endtask

   function automatic logic port_ready(input rsp_owner_e port);
      return (port == CPU) ? bus.cpu_req_ready : bus.dbg_req_ready;
   endfunction

   // Called just after a rising edge; returns just after the edge that transfers the request
   task automatic xfer(input rsp_owner_e port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] we, input logic expect_now);
      int w;
      drive(port, 1'b1, a, d, we);
      w = 0;
      @(negedge clk);
      while (!port_ready(port) && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check("xfer_timeout", 1'b1, 1'b0);
      if (expect_now) check("no_bubble", w, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input rsp_owner_e port);
      drive(port, 1'b0, '0, '0, '0);
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      bus.mem_dout = '0;
      drive(CPU, 1'b1, 14'h0, '0, '0);
      drive(DBG, 1'b1, 14'h1, '0, '0);
      repeat (30) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("first_ready", {bus.cpu_req_ready, bus.dbg_req_ready}, 2'b10);
      @(posedge clk);
      #1;
      idle(CPU);
      idle(DBG);
      gap(2);

      // CPU store then load back-to-back
      xfer(CPU, 14'h10, 32'hDEADBEEF, 4'hF, 1'b1);
      xfer(CPU, 14'h10, 32'h0, 4'h0, 1'b1);
      idle(CPU);
      gap(2);

      // Debug full write, byte-lane write, read back
      xfer(DBG, 14'h20, 32'h11223344, 4'hF, 1'b1);
      xfer(DBG, 14'h20, 32'h5555AA55, 4'b0010, 1'b1);
      xfer(DBG, 14'h20, 32'h0, 4'h0, 1'b1);
      idle(DBG);
      gap(2);
      check("byte_lane_ref", ref_mem[14'h20], 32'h1122AA44);

      // CPU reads at full throughput
      for (int i = 0; i < 4; i++) begin
         xfer(CPU, (i % 2 == 0) ? 14'h10 : 14'h20, 32'h0, 4'h0, 1'b1);
      end
      idle(CPU);
      gap(2);

      // Continuous contention: 8 CPU grants then one forced debug grant
      drive(CPU, 1'b1, 14'h10, '0, '0);
      drive(DBG, 1'b1, 14'h20, '0, '0);
      for (int k = 0; k < 27; k++) begin
         @(negedge clk);
         check("starve_pattern", {bus.cpu_req_ready, bus.dbg_req_ready},
               (k % 9 == 8) ? 2'b01 : 2'b10);
         check("starve_cnt_max", dut.u_starve.count > 8'd8, 1'b0);
         @(posedge clk);
         #1;
      end
      idle(CPU);
      idle(DBG);
      gap(2);

      // Debug drops out after 3 losses; counter must restart
      drive(CPU, 1'b1, 14'h10, '0, '0);
      drive(DBG, 1'b1, 14'h20, '0, '0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("pre_drop", {bus.cpu_req_ready, bus.dbg_req_ready}, 2'b10);
         @(posedge clk);
         #1;
      end
      idle(DBG);
      gap(1);
      drive(DBG, 1'b1, 14'h20, '0, '0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         check("post_drop", {bus.cpu_req_ready, bus.dbg_req_ready},
               (k == 8) ? 2'b01 : 2'b10);
         @(posedge clk);
         #1;
      end
      idle(CPU);
      idle(DBG);
      gap(2);

      // Reset right after a CPU read grant drops the response
      drive(CPU, 1'b1, 14'h10, '0, '0);
      @(negedge clk);
      check("pre_reset_grant", bus.cpu_req_ready, 1'b1);
      @(posedge clk);
      #1;
      idle(CPU);
      rst = 1'b1;
      gap(2);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_rsp", {bus.cpu_rsp_valid, bus.dbg_rsp_valid}, 2'b00);
      check("post_reset_owner", dut.rsp_owner, NONE);
      gap(3);

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
